// File: rtl/multicycle_control_unit_if.sv
// Bundle between the multi-cycle control unit and the core: opcode and memory
// acks in, datapath/memory strobes and status out.
interface multicycle_control_unit_if #(
  parameter int OP_W     = 5,
  parameter int ALU_OP_W = 2,
  parameter int CNT_W    = 32
);
  logic [OP_W-1:0]     op;
  logic                imem_ack;
  logic                dmem_ack;
  logic                imem_req;
  logic                ir_write;
  logic                dmem_req;
  logic                dmem_we;
  logic                pc_write;
  logic                branch;
  logic                alu_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic [1:0]          wb_sel;
  logic                reg_write;
  logic                retire;
  logic [CNT_W-1:0]    instret;
  logic                halted;
  logic                trap;
  logic [1:0]          trap_cause;

  modport master (
    input  op, imem_ack, dmem_ack,
    output imem_req, ir_write, dmem_req, dmem_we, pc_write, branch, alu_src,
           alu_op, wb_sel, reg_write, retire, instret, halted, trap, trap_cause
  );

  modport slave (
    output op, imem_ack, dmem_ack,
    input  imem_req, ir_write, dmem_req, dmem_we, pc_write, branch, alu_src,
           alu_op, wb_sel, reg_write, retire, instret, halted, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with wait-state
// tolerant memory handshakes, bus timeout, illegal-opcode trap and halt.
module multicycle_control_unit #(
  parameter int OP_W        = 5,
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  localparam logic [OP_W-1:0] OPC_LOAD   = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OPC_ARI    = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OPC_AUIPC  = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OPC_STORE  = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] OPC_ARR    = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OPC_LUI    = OP_W'(5'b01101);
  localparam logic [OP_W-1:0] OPC_BR     = OP_W'(5'b11000);
  localparam logic [OP_W-1:0] OPC_JALR   = OP_W'(5'b11001);
  localparam logic [OP_W-1:0] OPC_JAL    = OP_W'(5'b11011);
  localparam logic [OP_W-1:0] OPC_SYSTEM = OP_W'(5'b11100);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [1:0]        trap_cause_q, trap_cause_d;

  logic                imem_req, ir_write_raw, dmem_req, dmem_we, pc_write, branch;
  logic                alu_src, reg_write, retire_raw, halted, trap;
  logic [ALU_OP_W-1:0] alu_op;
  logic [1:0]          wb_sel;
  logic                timeout;

  function automatic logic op_legal(input logic [OP_W-1:0] o);
    case (o)
      OPC_LOAD, OPC_ARI, OPC_AUIPC, OPC_STORE, OPC_ARR,
      OPC_LUI, OPC_BR, OPC_JALR, OPC_JAL: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Timeout fires on the cycle the wait count would reach MEM_TIMEOUT; an ack that cycle wins.
  assign timeout = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wait_d       = '0;
    trap_cause_d = trap_cause_q;
    imem_req     = 1'b0;
    ir_write_raw = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    alu_src      = 1'b0;
    alu_op       = '0;
    wb_sel       = 2'b00;
    reg_write    = 1'b0;
    retire_raw   = 1'b0;
    halted       = 1'b0;
    trap         = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_write_raw = 1'b1;
          state_d      = S_DECODE;
        end else if (timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b10;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        op_d = bus.op;
        if (bus.op == OPC_SYSTEM)  state_d = S_HALT;
        else if (op_legal(bus.op)) state_d = S_EXEC;
        else begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (op_q)
          OPC_ARR:   alu_op = ALU_OP_W'(2'b10);
          OPC_ARI: begin
            alu_op  = ALU_OP_W'(2'b11);
            alu_src = 1'b1;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OPC_AUIPC: alu_src = 1'b1;
          OPC_BR: begin
            alu_op     = ALU_OP_W'(2'b01);
            branch     = 1'b1;
            retire_raw = 1'b1;
            state_d    = S_FETCH;
          end
          OPC_JAL, OPC_JALR: pc_write = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OPC_STORE);
        if (bus.dmem_ack) begin
          if (op_q == OPC_STORE) begin
            retire_raw = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b11;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
        case (op_q)
          OPC_LOAD:          wb_sel = 2'b01;
          OPC_JAL, OPC_JALR: wb_sel = 2'b10;
          OPC_LUI:           wb_sel = 2'b11;
          default:           wb_sel = 2'b00;
        endcase
      end
      S_HALT:  halted = 1'b1;
      S_TRAP:  trap   = 1'b1;
      default: state_d = S_FETCH;
    endcase

    instret_d = instret_q + CNT_W'(retire_raw);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      op_q         <= '0;
      wait_q       <= '0;
      instret_q    <= '0;
      trap_cause_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wait_q       <= wait_d;
      instret_q    <= instret_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  // The ack-completion strobes are masked in a reset cycle so an aborted access never commits.
  assign bus.imem_req   = imem_req;
  assign bus.ir_write   = ir_write_raw & ~rst;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.pc_write   = pc_write;
  assign bus.branch     = branch;
  assign bus.alu_src    = alu_src;
  assign bus.alu_op     = alu_op;
  assign bus.wb_sel     = wb_sel;
  assign bus.reg_write  = reg_write;
  assign bus.retire     = retire_raw & ~rst;
  assign bus.instret    = instret_q;
  assign bus.halted     = halted;
  assign bus.trap       = trap;
  assign bus.trap_cause = trap_cause_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: table of per-opcode instruction
// vectors plus hand sequences for timeout, trap, halt, reset abort and wrap.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OP_W(5), .ALU_OP_W(2), .CNT_W(4)) bus ();

  multicycle_control_unit #(
    .OP_W(5), .ALU_OP_W(2), .MEM_TIMEOUT(4), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic [4:0] op;
    int         iw;      // imem wait cycles before ack
    int         dw;      // dmem wait cycles before ack
    int         cyc;     // cycles from first FETCH cycle to retire, inclusive
    logic [1:0] alu_op;  // in EXEC
    logic       alu_src; // in EXEC
    int         regw;    // reg_write cycles
    logic [1:0] wb_sel;  // while reg_write
    int         br;      // branch cycles
    int         pcw;     // pc_write cycles
    int         dreq;    // dmem_req cycles
    logic       dwe;     // dmem_we seen while dmem_req
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [3:0] instret_model = 4'd0;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    instret_model = 4'd0;
  endtask

  task automatic run_instr(input vec_t v);
    int c = 0, icnt = 0, dcnt = 0, cyc = 0;
    int regw = 0, br = 0, pcw = 0, dreq = 0;
    logic [1:0] ex_aluop = 2'b00, wbs = 2'b00;
    logic ex_src = 1'b0, dwe = 1'b0;
    bit done = 1'b0;
    bus.op = v.op;
    for (int k = 0; k < 40 && !done; k++) begin
      c++;
      bus.imem_ack = bus.imem_req && (icnt == v.iw);
      bus.dmem_ack = bus.dmem_req && (dcnt == v.dw);
      #1;
      if (bus.imem_req) icnt++;
      if (bus.dmem_req) begin
        dreq++;
        dcnt++;
        dwe = dwe | bus.dmem_we;
      end
      if (c == v.iw + 3) begin
        ex_aluop = bus.alu_op;
        ex_src   = bus.alu_src;
      end
      if (bus.reg_write) begin
        regw++;
        wbs = bus.wb_sel;
      end
      if (bus.branch)   br++;
      if (bus.pc_write) pcw++;
      if (bus.retire) begin
        done = 1'b1;
        cyc  = c;
      end
      step();
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    if (done) instret_model = instret_model + 4'd1;
    check({v.name, " cycles"},  32'(cyc),      32'(v.cyc));
    check({v.name, " alu_op"},  32'(ex_aluop), 32'(v.alu_op));
    check({v.name, " alu_src"}, 32'(ex_src),   32'(v.alu_src));
    check({v.name, " regw"},    32'(regw),     32'(v.regw));
    check({v.name, " wb_sel"},  32'(wbs),      32'(v.wb_sel));
    check({v.name, " branch"},  32'(br),       32'(v.br));
    check({v.name, " pcw"},     32'(pcw),      32'(v.pcw));
    check({v.name, " dreq"},    32'(dreq),     32'(v.dreq));
    check({v.name, " dwe"},     32'(dwe),      32'(v.dwe));
    check({v.name, " instret"}, 32'(bus.instret), 32'(instret_model));
  endtask

  // Runs until trap or halted appears (Moore, visible in the cycle after entry).
  task automatic run_to_stop(input logic [4:0] op, input bit dack_en,
                             output int cyc, output int regw);
    bit done = 1'b0;
    cyc  = 0;
    regw = 0;
    bus.op = op;
    for (int c = 1; c <= 40 && !done; c++) begin
      bus.imem_ack = bus.imem_req;
      bus.dmem_ack = dack_en && bus.dmem_req;
      #1;
      if (bus.reg_write) regw++;
      if (bus.trap || bus.halted) begin
        done = 1'b1;
        cyc  = c;
      end else begin
        step();
      end
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, regw, idle_bad;
    vecs[0]  = '{"arith_r",  5'b01100, 0, 0, 4, 2'b10, 1'b0, 1, 2'b00, 0, 0, 0, 1'b0};
    vecs[1]  = '{"arith_i",  5'b00100, 0, 0, 4, 2'b11, 1'b1, 1, 2'b00, 0, 0, 0, 1'b0};
    vecs[2]  = '{"auipc",    5'b00101, 0, 0, 4, 2'b00, 1'b1, 1, 2'b00, 0, 0, 0, 1'b0};
    vecs[3]  = '{"lui",      5'b01101, 0, 0, 4, 2'b00, 1'b0, 1, 2'b11, 0, 0, 0, 1'b0};
    vecs[4]  = '{"jal",      5'b11011, 0, 0, 4, 2'b00, 1'b0, 1, 2'b10, 0, 1, 0, 1'b0};
    vecs[5]  = '{"jalr",     5'b11001, 0, 0, 4, 2'b00, 1'b0, 1, 2'b10, 0, 1, 0, 1'b0};
    vecs[6]  = '{"branch",   5'b11000, 0, 0, 3, 2'b01, 1'b0, 0, 2'b00, 1, 0, 0, 1'b0};
    vecs[7]  = '{"store",    5'b01000, 0, 0, 4, 2'b00, 1'b1, 0, 2'b00, 0, 0, 1, 1'b1};
    vecs[8]  = '{"load_dw3", 5'b00000, 0, 3, 8, 2'b00, 1'b1, 1, 2'b01, 0, 0, 4, 1'b0};
    vecs[9]  = '{"store_w",  5'b01000, 2, 1, 7, 2'b00, 1'b1, 0, 2'b00, 0, 0, 2, 1'b1};
    vecs[10] = '{"arith_iw3",5'b01100, 3, 0, 7, 2'b10, 1'b0, 1, 2'b00, 0, 0, 0, 1'b0};

    bus.op = 5'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    step();
    do_reset();

    check("rst imem_req",   32'(bus.imem_req),   32'd1);
    check("rst strobes",    32'({bus.ir_write, bus.dmem_req, bus.dmem_we, bus.pc_write,
                                 bus.branch, bus.alu_src, bus.reg_write, bus.retire,
                                 bus.halted, bus.trap}), 32'd0);
    check("rst alu/wb",     32'({bus.alu_op, bus.wb_sel}), 32'd0);
    check("rst instret",    32'(bus.instret),    32'd0);
    check("rst trap_cause", 32'(bus.trap_cause), 32'd0);

    for (int i = 0; i < 11; i++) run_instr(vecs[i]);

    // 16 further branches wrap the 4-bit counter back to the same value.
    for (int i = 0; i < 16; i++) run_instr(vecs[6]);
    check("wrap instret", 32'(bus.instret), 32'd11);

    // imem timeout: four unacked FETCH cycles then TRAP cause 10.
    do_reset();
    bus.op = 5'b01100;
    for (int i = 0; i < 4; i++) begin
      check("tmo fetch req", 32'({bus.imem_req, bus.trap}), 32'b10);
      step();
    end
    check("tmo trap",       32'(bus.trap),       32'd1);
    check("tmo cause",      32'(bus.trap_cause), 32'b10);
    check("tmo imem_req",   32'(bus.imem_req),   32'd0);
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.imem_ack = 1'b1;
      bus.dmem_ack = 1'b1;
      #1;
      if (!bus.trap || bus.imem_req || bus.dmem_req || bus.reg_write || bus.retire) idle_bad++;
      step();
    end
    check("trap absorbing", 32'(idle_bad), 32'd0);
    do_reset();
    check("tmo recover", 32'({bus.imem_req, bus.trap, bus.trap_cause}), 32'b1000);

    // dmem timeout on a Load.
    run_to_stop(5'b00000, 1'b0, cyc, regw);
    check("dtmo cycle", 32'(cyc),            32'd8);
    check("dtmo cause", 32'(bus.trap_cause), 32'b11);
    check("dtmo regw",  32'(regw),           32'd0);

    // Illegal opcode.
    do_reset();
    run_to_stop(5'b11111, 1'b1, cyc, regw);
    check("ill cycle", 32'(cyc),            32'd3);
    check("ill cause", 32'(bus.trap_cause), 32'b01);

    // SYSTEM halts and stops fetching.
    do_reset();
    run_to_stop(5'b11100, 1'b1, cyc, regw);
    check("halt cycle", 32'(cyc),          32'd3);
    check("halt flags", 32'({bus.halted, bus.trap}), 32'b10);
    idle_bad = 0;
    for (int i = 0; i < 22; i++) begin
      bus.imem_ack = 1'b1;
      #1;
      if (!bus.halted || bus.imem_req || bus.ir_write || bus.retire) idle_bad++;
      step();
    end
    bus.imem_ack = 1'b0;
    check("halt idle", 32'(idle_bad), 32'd0);

    // Reset while a Load waits in MEM with ack present: the load is aborted.
    do_reset();
    bus.op = 5'b00000;
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    step();
    step();
    rst = 1'b1;
    bus.dmem_ack = 1'b1;
    #1;
    check("abort in mem",   32'({bus.dmem_req, bus.dmem_we}), 32'b10);
    check("abort no commit", 32'({bus.reg_write, bus.retire}), 32'b00);
    step();
    rst = 1'b0;
    bus.dmem_ack = 1'b0;
    regw = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.reg_write || bus.retire || !bus.imem_req) regw++;
      step();
    end
    check("abort fetch idle", 32'(regw),        32'd0);
    check("abort instret",    32'(bus.instret), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
